// File: rtl/sub_bytes_seq.sv
// Iterative AES forward SubBytes: LANES S-box lookups per clock over a
// 128-bit state, valid/ready in and out.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    input handshake, in_data byte 0 = [127:120]
//   out_valid/out_ready  output handshake, out_data same byte order
//   busy                 high while substituting or holding a result
module sub_bytes_seq #(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
              LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $fatal(1, "sub_bytes_seq: LANES must be 1,2,4,8 or 16");
        end
    endgenerate

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    // Ascending byte index so st_q[i] is byte i of the AES state.
    logic [0:15][7:0]  st_q, st_d;
    logic [3:0]        idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        st_d    = st_q;
        idx     = '0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    st_d    = in_data;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int l = 0; l < LANES; l++) begin
                    idx       = 4'(cnt_q) * 4'(LANES) + 4'(l);
                    st_d[idx] = SBOX[st_q[idx]];
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY) || (state_q == DONE);
    assign out_data  = st_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: one instance per legal LANES value, checked
// against a GF(2^8) inverse + affine model of the forward S-box.
module tb_sub_bytes_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         iv  [5];
    logic         ir  [5];
    logic [127:0] id  [5];
    logic         ov  [5];
    logic         orr [5];
    logic [127:0] od  [5];
    logic         bz  [5];

    int lanes [5] = '{1, 2, 4, 8, 16};

    sub_bytes_seq #(.LANES(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(id[0]), .out_valid(ov[0]), .out_ready(orr[0]),
        .out_data(od[0]), .busy(bz[0]));
    sub_bytes_seq #(.LANES(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(id[1]), .out_valid(ov[1]), .out_ready(orr[1]),
        .out_data(od[1]), .busy(bz[1]));
    sub_bytes_seq #(.LANES(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(id[2]), .out_valid(ov[2]), .out_ready(orr[2]),
        .out_data(od[2]), .busy(bz[2]));
    sub_bytes_seq #(.LANES(8)) u_l8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
        .in_data(id[3]), .out_valid(ov[3]), .out_ready(orr[3]),
        .out_data(od[3]), .busy(bz[3]));
    sub_bytes_seq #(.LANES(16)) u_l16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[4]), .in_ready(ir[4]),
        .in_data(id[4]), .out_valid(ov[4]), .out_ready(orr[4]),
        .out_data(od[4]), .busy(bz[4]));

    int npass = 0;
    int ntot  = 0;

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference S-box from field arithmetic.
    logic [7:0] sref [256];

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] x, int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sref();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sref[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^
                      rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model(logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = sref[d[127-8*i -: 8]];
        return r;
    endfunction

    int acc_cyc;

    task automatic accept(int k, logic [127:0] d);
        int n = 0;
        iv[k] = 1'b1;
        id[k] = d;
        while (!ir[k] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_ready", 128'(ir[k]), 128'd1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        iv[k] = 1'b0;
        id[k] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic finish(int k, logic [127:0] exp, int hold);
        int n = 0;
        logic bad = 1'b0;
        logic [127:0] snap;
        while (!ov[k] && n < 40) begin
            if (ir[k] || !bz[k]) bad = 1'b1;
            @(posedge clk); #1; n++;
        end
        chk("latency", 128'(n), 128'(16 / lanes[k]));
        chk("busy_flags", 128'(bad), 128'd0);
        chk("data", od[k], exp);
        snap = od[k];
        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!ov[k] || od[k] !== snap || ir[k] || !bz[k]) bad = 1'b1;
        end
        if (hold > 0) chk("backpressure_hold", 128'(bad), 128'd0);
        orr[k] = 1'b1;
        @(posedge clk); #1;
        orr[k] = 1'b0;
        chk("idle_after", 128'({ir[k], ov[k], bz[k]}), 128'(3'b100));
        chk("idle_data", od[k], exp);
    endtask

    logic [127:0] d;
    int t0;

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            iv[k] = 1'b0; orr[k] = 1'b0; id[k] = '0;
        end
        build_sref();
        #3;
        for (int k = 0; k < 5; k++) begin
            chk("reset_flags", 128'({ir[k], ov[k], bz[k]}), 128'(3'b100));
            chk("reset_data", od[k], 128'd0);
        end
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        chk("sref_00", 128'(sref[0]), 128'h63);
        chk("sref_ff", 128'(sref[255]), 128'h16);

        accept(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        finish(0, 128'hd42711aee0bf98f1b8b45de51e415230, 0);

        accept(4, 128'h000102030405060708090a0b0c0d0e0f);
        finish(4, 128'h637c777bf26b6fc53001672bfed7ab76, 0);

        accept(2, {16{8'h00}});
        t0 = acc_cyc;
        finish(2, {16{8'h63}}, 0);
        accept(2, {16{8'hff}});
        chk("accept_spacing", 128'(acc_cyc - t0), 128'd6);
        finish(2, {16{8'h16}}, 0);

        accept(1, 128'h00112233445566778899aabbccddeeff);
        finish(1, model(128'h00112233445566778899aabbccddeeff), 10);

        // Abort mid-substitution, then prove no residue.
        accept(0, {16{8'h5a}});
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midreset_flags", 128'({ir[0], ov[0], bz[0]}), 128'(3'b100));
        chk("midreset_data", od[0], 128'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        accept(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        finish(0, 128'hd42711aee0bf98f1b8b45de51e415230, 0);

        for (int k = 0; k < 5; k++) begin
            for (int t = 0; t < 1000; t++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                accept(k, d);
                finish(k, model(d),
                       ($urandom_range(0, 15) == 0) ?
                       int'($urandom_range(1, 3)) : 0);
            end
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
